// File: rtl/pwm_capture_if.sv
// APB slave bus bundle for pwm_capture.
interface pwm_capture_if;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        psel;
  logic        penable;
  logic        pwrite;

  modport master (output paddr, pwdata, psel, penable, pwrite, input prdata);
  modport slave  (input paddr, pwdata, psel, penable, pwrite, output prdata);
endinterface

// File: rtl/pwm_capture.sv
// PWM input capture: per-channel period / high-time measurement behind APB.
// Optional interrupt output enabled by defining PWM_CAPTURE_IRQ_EN.
// Register map per channel (byte offset {chan, reg, 2'b00}):
//   0 CTRL [0] enable [1] invert [2] irq enable, 1 PERIOD, 2 HIGH,
//   3 STATUS [0] valid [1] overflow (write-1-to-clear).
// n_rst is synchronous and active-high.

// One capture channel: synchronizer, edge detect, measurement FSM.
module pwm_capture_ch #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             pwm_i,
  input  logic             en_i,
  input  logic             inv_i,
  input  logic [1:0]       w1c_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             ovf_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       sync_q;
  logic             s_d_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, shadow_q, shadow_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             valid_q, valid_d, ovf_q, ovf_d;
  logic             s, rise, fall, set_valid, set_ovf;

  assign s    = sync_q[1] ^ inv_i;
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  // Measurement FSM; the counter saturates and aborts at all-ones.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    period_d  = period_q;
    high_d    = high_q;
    set_valid = 1'b0;
    set_ovf   = 1'b0;
    if (!en_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (rise) begin
          state_d = S_HIGH;
          cnt_d   = CNT_W'(1);
        end
        S_HIGH: if (cnt_q == CNT_MAX) begin
          set_ovf = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (fall) begin
            shadow_d = cnt_q;
            state_d  = S_LOW;
          end
        end
        S_LOW: if (cnt_q == CNT_MAX) begin
          set_ovf = 1'b1;
          state_d = S_IDLE;
        end else if (rise) begin
          period_d  = cnt_q;
          high_d    = shadow_q;
          set_valid = 1'b1;
          cnt_d     = CNT_W'(1);
          state_d   = S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
    // a new event beats a simultaneous clear
    valid_d = set_valid | (valid_q & ~w1c_i[0]);
    ovf_d   = set_ovf   | (ovf_q   & ~w1c_i[1]);
  end

  // Input synchronizer, edge flop and measurement state.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      sync_q   <= '0;
      s_d_q    <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], pwm_i};
      s_d_q    <= s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign period_o = period_q;
  assign high_o   = high_q;
  assign valid_o  = valid_q;
  assign ovf_o    = ovf_q;
endmodule

module pwm_capture #(
  parameter int NUM_CHANNELS = 2,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    n_rst,
  pwm_capture_if.slave            apb,
  input  logic [NUM_CHANNELS-1:0] pwm_in
`ifdef PWM_CAPTURE_IRQ_EN
  ,
  output logic                    irq
`endif
);
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
`ifdef PWM_CAPTURE_IRQ_EN
  localparam int CTRL_W = 3;
`else
  localparam int CTRL_W = 2;
`endif

  logic [NUM_CHANNELS-1:0][CTRL_W-1:0] ctrl_q;
  logic [NUM_CHANNELS-1:0][CNT_W-1:0]  period, high;
  logic [NUM_CHANNELS-1:0]             valid, ovf, wsel;
  logic [NUM_CHANNELS-1:0][1:0]        w1c;
  logic [CH_W-1:0]                     chan;
  logic [1:0]                          rsel;
  logic                                chan_ok, wr_en;
  logic                                unused;

  assign chan    = apb.paddr[4 +: CH_W];
  assign rsel    = apb.paddr[3:2];
  assign chan_ok = {{(32-CH_W){1'b0}}, chan} < 32'(NUM_CHANNELS);
  assign wr_en   = apb.psel & apb.penable & apb.pwrite;
  assign unused  = ^{apb.paddr, apb.pwdata};

  // Decode which channel a write lands on and its W1C bits.
  always_comb begin
    wsel = '0;
    w1c  = '0;
    if (wr_en && chan_ok) wsel[chan] = 1'b1;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (wsel[i] && rsel == 2'd3) w1c[i] = apb.pwdata[1:0];
  end

  // CTRL registers; only the implemented bits are stored.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      ctrl_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++)
        if (wsel[i] && rsel == 2'd0) ctrl_q[i] <= apb.pwdata[CTRL_W-1:0];
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CHANNELS; g++) begin : g_ch
      pwm_capture_ch #(.CNT_W(CNT_W)) u_ch (
        .clk      (clk),
        .n_rst    (n_rst),
        .pwm_i    (pwm_in[g]),
        .en_i     (ctrl_q[g][0]),
        .inv_i    (ctrl_q[g][1]),
        .w1c_i    (w1c[g]),
        .period_o (period[g]),
        .high_o   (high[g]),
        .valid_o  (valid[g]),
        .ovf_o    (ovf[g])
      );
    end
  endgenerate

  // Combinational read mux; held at zero during reset.
  always_comb begin
    apb.prdata = '0;
    if (!n_rst && apb.psel && !apb.pwrite && chan_ok) begin
      case (rsel)
        2'd0: apb.prdata = 32'(ctrl_q[chan]);
        2'd1: apb.prdata = 32'(period[chan]);
        2'd2: apb.prdata = 32'(high[chan]);
        2'd3: apb.prdata = {30'b0, ovf[chan], valid[chan]};
        default: apb.prdata = '0;
      endcase
    end
  end

`ifdef PWM_CAPTURE_IRQ_EN
  logic irq_q;
  logic [NUM_CHANNELS-1:0] irq_src;

  always_comb begin
    irq_src = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      irq_src[i] = (valid[i] | ovf[i]) & ctrl_q[i][2];
  end

  // Registered interrupt: one cycle behind the status bits.
  always_ff @(posedge clk) begin
    if (n_rst) irq_q <= 1'b0;
    else       irq_q <= |irq_src;
  end

  assign irq = irq_q;
`endif
endmodule
